// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg
//   Definitions shared by the AXI4-lite master and slave blocks:
//     - response codes (OKAY / EXOKAY / SLVERR / DECERR)
//     - read-master FSM state encoding
//     - default AxPROT value
// ---------------------------------------------------------------------------
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi4_lite_read_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_read_master
//   Single-beat AXI4-lite read initiator. A core-side READ_START (taken only
//   while idle) launches one AR transfer; the R beat is captured and returned
//   on READ_DATA / READ_ERR together with a one-cycle READ_DONE pulse.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   READ_ADDR, READ_START    core request (address + strobe)
//   READ_DATA, READ_DONE,    core response: data (held until next completion),
//   READ_ERR, BUSY           completion pulse, error flag, not-idle flag
//   AR_ADDR, AR_VALID,       AXI read-address channel
//   AR_READY, AR_PORT
//   R_DATA, R_RESP,          AXI read-data channel
//   R_VALID, R_READY
//
// Build option
//   AXI_READ_TIMEOUT_EN      adds a watchdog that aborts a transfer stuck for
//                            TIMEOUT_CYCLES cycles in ADDR or DATA, reporting
//                            READ_ERR=1 with READ_DATA=0. The abort drops
//                            AR_VALID without a handshake, so it is a debug
//                            aid only and not AXI-compliant.
// ---------------------------------------------------------------------------
module axi4_lite_read_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] READ_ADDR,
    input  logic              READ_START,
    output logic [DATA_W-1:0] READ_DATA,
    output logic              READ_DONE,
    output logic              READ_ERR,
    output logic              BUSY,
    output logic [ADDR_W-1:0] AR_ADDR,
    output logic              AR_VALID,
    input  logic              AR_READY,
    output logic [2:0]        AR_PORT,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    input  logic              R_VALID,
    output logic              R_READY
);

    rd_state_e         state, state_nx;
    logic              ar_valid_nx, r_ready_nx, done_nx, err_nx;
    logic [ADDR_W-1:0] ar_addr_nx;
    logic [DATA_W-1:0] data_nx;

    assign AR_PORT = PROT_DEFAULT;
    // Pure decode of the state register, so it carries no combinational path
    // from any input.
    assign BUSY    = (state != ST_IDLE);

`ifdef AXI_READ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;

    // Restarts on every state change, so it measures time spent in the
    // current wait (AR handshake or R beat), not the whole transaction.
    always_ff @(posedge CLK) begin
        if (RST || state_nx != state) wd_cnt <= '0;
        else if (state != ST_IDLE)    wd_cnt <= wd_cnt + 16'd1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_nx    = state;
        ar_valid_nx = AR_VALID;
        ar_addr_nx  = AR_ADDR;
        r_ready_nx  = R_READY;
        data_nx     = READ_DATA;
        err_nx      = READ_ERR;
        done_nx     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (READ_START) begin
                    ar_addr_nx  = READ_ADDR;
                    ar_valid_nx = 1'b1;
                    state_nx    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (AR_VALID && AR_READY) begin
                    ar_valid_nx = 1'b0;
                    r_ready_nx  = 1'b1;
                    state_nx    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (R_VALID && R_READY) begin
                    data_nx    = R_DATA;
                    err_nx     = !(R_RESP == RESP_OKAY || R_RESP == RESP_EXOKAY);
                    done_nx    = 1'b1;
                    r_ready_nx = 1'b0;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

`ifdef AXI_READ_TIMEOUT_EN
        // state_nx == state means the pending handshake did not happen.
        if (state != ST_IDLE && state_nx == state && wd_cnt == TO_LAST) begin
            ar_valid_nx = 1'b0;
            r_ready_nx  = 1'b0;
            data_nx     = '0;
            err_nx      = 1'b1;
            done_nx     = 1'b1;
            state_nx    = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            AR_VALID  <= 1'b0;
            AR_ADDR   <= '0;
            R_READY   <= 1'b0;
            READ_DATA <= '0;
            READ_ERR  <= 1'b0;
            READ_DONE <= 1'b0;
        end else begin
            state     <= state_nx;
            AR_VALID  <= ar_valid_nx;
            AR_ADDR   <= ar_addr_nx;
            R_READY   <= r_ready_nx;
            READ_DATA <= data_nx;
            READ_ERR  <= err_nx;
            READ_DONE <= done_nx;
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_read_master
//   Directed bench for axi4_lite_read_master. Inputs change 1 ns after each
//   rising edge, and outputs are checked at that same point.
//   With AXI_READ_TIMEOUT_EN defined the watchdog scenario runs as well
//   (TIMEOUT_CYCLES=16).
// ---------------------------------------------------------------------------
module tb_axi4_lite_read_master;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] READ_ADDR;
    logic          READ_START;
    logic [DW-1:0] READ_DATA;
    logic          READ_DONE, READ_ERR, BUSY;
    logic [AW-1:0] AR_ADDR;
    logic          AR_VALID, AR_READY;
    logic [2:0]    AR_PORT;
    logic [DW-1:0] R_DATA;
    logic [1:0]    R_RESP;
    logic          R_VALID, R_READY;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;
    int done_base, hs_base;

    axi4_lite_read_master #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .READ_ADDR(READ_ADDR), .READ_START(READ_START),
        .READ_DATA(READ_DATA), .READ_DONE(READ_DONE),
        .READ_ERR(READ_ERR), .BUSY(BUSY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .AR_PORT(AR_PORT),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    always #5 CLK = ~CLK;

    // Mid-cycle sampling: counts completion pulses and AR handshakes.
    always @(negedge CLK) begin
        if (READ_DONE)            done_cnt++;
        if (AR_VALID && AR_READY) hs_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses READ_START for one edge; returns in the cycle after acceptance.
    task automatic start_read(input logic [63:0] addr);
        READ_ADDR  = addr;
        READ_START = 1'b1;
        tick();
        READ_START = 1'b0;
    endtask

    initial begin
        RST = 1'b1; READ_ADDR = '0; READ_START = 1'b0;
        AR_READY = 1'b0; R_DATA = '0; R_RESP = 2'b00; R_VALID = 1'b0;
        tick(); tick();

        // ---- reset state ----
        chk("rst_ar_valid", AR_VALID, 0);
        chk("rst_r_ready", R_READY, 0);
        chk("rst_ar_addr", AR_ADDR, 0);
        chk("rst_read_data", READ_DATA, 0);
        chk("rst_done", READ_DONE, 0);
        chk("rst_err", READ_ERR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_prot", AR_PORT, 0);
        RST = 1'b0;
        tick();

        // ---- basic read, minimum latency ----
        AR_READY = 1'b1;
        start_read(64'h8000_0010);                 // cycle 1
        chk("basic_ar_valid", AR_VALID, 1);
        chk("basic_ar_addr", AR_ADDR, 64'h8000_0010);
        chk("basic_busy", BUSY, 1);
        chk("basic_r_ready_c1", R_READY, 0);
        R_VALID = 1'b1; R_DATA = 64'hDEAD_BEEF_0123_4567; R_RESP = 2'b00;
        tick();                                    // cycle 2
        chk("basic_r_ready_c2", R_READY, 1);
        chk("basic_ar_valid_c2", AR_VALID, 0);
        chk("basic_done_c2", READ_DONE, 0);
        tick();                                    // cycle 3
        chk("basic_done_c3", READ_DONE, 1);
        chk("basic_data", READ_DATA, 64'hDEAD_BEEF_0123_4567);
        chk("basic_err", READ_ERR, 0);
        chk("basic_r_ready_c3", R_READY, 0);
        chk("basic_busy_c3", BUSY, 0);
        R_VALID = 1'b0; AR_READY = 1'b0;
        tick();
        chk("basic_done_once", READ_DONE, 0);
        chk("basic_data_hold", READ_DATA, 64'hDEAD_BEEF_0123_4567);

        // ---- backpressure on AR and R ----
        done_base = done_cnt;
        start_read(64'h0000_1000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ar_valid", AR_VALID, 1);
            chk("bp_ar_addr", AR_ADDR, 64'h0000_1000);
            chk("bp_r_ready_addr", R_READY, 0);
            tick();
        end
        AR_READY = 1'b1;
        tick();
        AR_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_r_ready", R_READY, 1);
            chk("bp_no_done", READ_DONE, 0);
            tick();
        end
        R_VALID = 1'b1; R_DATA = 64'h55AA; R_RESP = 2'b01;   // EXOKAY
        tick();
        chk("bp_done", READ_DONE, 1);
        chk("bp_data", READ_DATA, 64'h55AA);
        chk("bp_err_exokay", READ_ERR, 0);
        R_VALID = 1'b0;
        tick();
        chk("bp_single_done", done_cnt - done_base, 1);

        // ---- error response, then OKAY clears it ----
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 64'h1; R_RESP = 2'b10;
        start_read(64'h2000);
        tick(); tick();
        chk("err_done", READ_DONE, 1);
        chk("err_flag", READ_ERR, 1);
        chk("err_data", READ_DATA, 64'h1);
        tick();
        chk("err_hold", READ_ERR, 1);
        R_DATA = 64'h77; R_RESP = 2'b00;
        start_read(64'h2008);
        tick(); tick();
        chk("ok_after_err_done", READ_DONE, 1);
        chk("ok_after_err_flag", READ_ERR, 0);
        chk("ok_after_err_data", READ_DATA, 64'h77);
        tick();

        // ---- start while busy ignored; start in DONE cycle accepted ----
        done_base = done_cnt; hs_base = hs_cnt;
        R_DATA = 64'hA1;
        start_read(64'h3000);                       // cycle 1, ADDR
        READ_ADDR = 64'h3333; READ_START = 1'b1;    // held through ADDR and DATA
        tick();                                     // cycle 2, DATA
        tick();                                     // cycle 3, DONE
        chk("b2b_done1", READ_DONE, 1);
        chk("b2b_addr_kept", AR_ADDR, 64'h3000);
        READ_ADDR = 64'h4000;                       // START still high
        tick();
        READ_START = 1'b0;
        chk("b2b_ar_valid2", AR_VALID, 1);
        chk("b2b_ar_addr2", AR_ADDR, 64'h4000);
        R_DATA = 64'hA2;
        tick(); tick();
        chk("b2b_done2", READ_DONE, 1);
        chk("b2b_data2", READ_DATA, 64'hA2);
        tick();
        chk("b2b_done_count", done_cnt - done_base, 2);
        chk("b2b_hs_count", hs_cnt - hs_base, 2);

        // ---- reset while in DATA ----
        R_VALID = 1'b0; AR_READY = 1'b1;
        done_base = done_cnt;
        start_read(64'h5000);
        tick();
        chk("rmid_in_data", R_READY, 1);
        RST = 1'b1; R_VALID = 1'b1; R_DATA = 64'hCC;
        tick();
        chk("rmid_r_ready", R_READY, 0);
        chk("rmid_busy", BUSY, 0);
        chk("rmid_done", READ_DONE, 0);
        chk("rmid_data", READ_DATA, 0);
        RST = 1'b0; R_VALID = 1'b0;
        tick(); tick();
        chk("rmid_no_done", done_cnt - done_base, 0);
        R_VALID = 1'b1; R_DATA = 64'hBB; R_RESP = 2'b00;
        start_read(64'h6000);
        tick(); tick();
        chk("rmid_after_done", READ_DONE, 1);
        chk("rmid_after_data", READ_DATA, 64'hBB);
        R_VALID = 1'b0; AR_READY = 1'b0;
        tick();

`ifdef AXI_READ_TIMEOUT_EN
        // ---- watchdog: AR_READY never rises ----
        start_read(64'h7000);                       // cycle 1, AR_VALID rose
        for (int i = 1; i < 16; i++) begin
            chk("to_waiting", READ_DONE, 0);
            chk("to_ar_valid", AR_VALID, 1);
            tick();
        end
        tick();                                     // cycle 17
        chk("to_done", READ_DONE, 1);
        chk("to_err", READ_ERR, 1);
        chk("to_data", READ_DATA, 0);
        chk("to_ar_drop", AR_VALID, 0);
        chk("to_busy", BUSY, 0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
